// File: rtl/fifo_down_split.sv
// 64-to-32 bit downconverting FIFO: buffers 64-bit words, emits upper half then lower half.
// Optional drop counter is built when FIFO_DOWN_SPLIT_OVF_EN is defined.
module fifo_down_split #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [63:0]   in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_data,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic [15:0]   ovf_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

    logic [63:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [31:0] r_hold_lo;
    logic [31:0] r_out_data;
    logic        r_out_valid;
    state_t      r_state;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [63:0] w_rd_word;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push    = in_valid && !w_full;
    // The holding register is free when idle, or when its lower beat is leaving this cycle.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_LO) && out_ready));
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    assign in_ready  = !w_full;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Upper half goes straight to the output register; only the lower half needs holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold_lo   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold_lo   <= w_rd_word[31:0];
                        r_out_data  <= w_rd_word[63:32];
                        r_out_valid <= 1'b1;
                        r_state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (out_ready) begin
                        r_out_data <= r_hold_lo;
                        r_state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (out_ready) begin
                        if (w_pop) begin
                            r_hold_lo  <= w_rd_word[31:0];
                            r_out_data <= w_rd_word[63:32];
                            r_state    <= S_HI;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_DOWN_SPLIT_OVF_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (in_valid && w_full && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_down_split.sv
// Bench for fifo_down_split: queue-based reference model checked every cycle plus literal checks.
module tb_fifo_down_split;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [63:0]   in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready = 1'b0;
    logic [AW:0]   level;
    logic [15:0]   ovf_cnt;

    int total = 0;
    int bad   = 0;

    fifo_down_split #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus the word being emitted and which half is out.
    logic [63:0] m_q[$];
    logic [63:0] m_hold;
    int          m_phase;   // 0 none, 1 upper half showing, 2 lower half showing
    int          m_ovf;

    task automatic model_clear();
        m_q.delete();
        m_hold  = '0;
        m_phase = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        bit          rdy;
        bit          xfer;
        bit          free;
        rdy  = (m_q.size() < DEPTH);
        xfer = (m_phase != 0) && out_ready;
        free = (m_phase == 0) || (m_phase == 2 && xfer);
        if (m_phase == 1 && xfer) m_phase = 2;
        if (free) begin
            if (m_q.size() > 0) begin
                m_hold  = m_q.pop_front();
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
        if (in_valid && rdy) m_q.push_back(in_data);
`ifdef FIFO_DOWN_SPLIT_OVF_EN
        if (in_valid && !rdy && m_ovf < 65535) m_ovf++;
`endif
    endtask

    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (rst) model_clear();
            chk("model_level", 64'(level), 64'(m_q.size()));
            chk("model_in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
            chk("model_out_valid", 64'(out_valid), 64'(m_phase != 0));
            if (m_phase == 1) chk("model_beat_hi", 64'(out_data), 64'(m_hold[63:32]));
            if (m_phase == 2) chk("model_beat_lo", 64'(out_data), 64'(m_hold[31:0]));
            chk("model_ovf", 64'(ovf_cnt), 64'(m_ovf));
            if (!rst) model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((out_valid || level != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_in_budget", 64'(n < 300), 64'd1);
    endtask

    logic [63:0] words [10];
    int run;
    int maxrun;
    int acc;
    int n;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);

        // Single word, first beat two cycles after in_valid
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1122_3344_5566_7788;
        step();
        in_valid = 1'b0;
        chk("single_level_n", 64'(level), 64'd1);
        chk("single_valid_n", 64'(out_valid), 64'd0);
        step();
        chk("single_valid_n1", 64'(out_valid), 64'd1);
        chk("single_hi", 64'(out_data), 64'h1122_3344);
        chk("single_level_n1", 64'(level), 64'd0);
        step();
        chk("single_lo", 64'(out_data), 64'h5566_7788);
        step();
        chk("single_done_valid", 64'(out_valid), 64'd0);
        chk("single_done_level", 64'(level), 64'd0);

        // Back-to-back: four words give eight gapless beats
        run = 0;
        maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4);
            in_data  = {24'h0, 8'($urandom), 24'h0, 8'($urandom)};
            step();
            if (out_valid) run++; else run = 0;
            if (run > maxrun) maxrun = run;
        end
        in_valid = 1'b0;
        chk("b2b_gapless_beats", 64'(maxrun), 64'd8);

        // Backpressure holds the upper beat stable
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1122_3344_5566_7788;
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", 64'(out_data), 64'h1122_3344);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_lo", 64'(out_data), 64'h5566_7788);
        step();
        chk("bp_release_done", 64'(out_valid), 64'd0);

        // Full and overflow
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            words[i] = {$urandom, $urandom};
            in_valid = 1'b1;
            in_data  = words[i];
            step();
        end
        in_valid = 1'b0;
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
`ifdef FIFO_DOWN_SPLIT_OVF_EN
        chk("full_ovf", 64'(ovf_cnt), 64'd1);
`else
        chk("full_ovf", 64'(ovf_cnt), 64'd0);
`endif
        chk("full_hold_word1", 64'(out_data), 64'(words[0][63:32]));
        drain();

        // Wrap-around: 40 accepted words, consumer toggling
        acc = 0;
        n   = 0;
        while (acc < 40 && n < 1000) begin
            in_valid  = in_ready;
            in_data   = {$urandom, $urandom};
            out_ready = n[0];
            if (in_valid) acc++;
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("wrap_accepted", 64'(acc), 64'd40);
        drain();

        // Random traffic including drops
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        drain();

        // Reset asserted while in LO with level 3
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            words[i] = {$urandom, $urandom};
            in_valid = 1'b1;
            in_data  = words[i];
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_rst_level", 64'(level), 64'd3);
        chk("pre_rst_lo", 64'(out_data), 64'(words[0][31:0]));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_ovf", 64'(ovf_cnt), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_hi", 64'(out_data), 64'hDEAD_BEEF);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        step();
        chk("post_rst_lo", 64'(out_data), 64'hCAFE_F00D);
        drain();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_down_split.md
# fifo_down_split

Single-clock 64-to-32-bit width downconverter and buffer. It accepts 64-bit words with a valid/ready handshake, queues them in a small FIFO, and emits each word as two 32-bit beats with a valid/ready handshake, upper half first. It is the unpacking counterpart to the team's 32-to-64 packing FIFO stage and returns packed 64-bit data to a 32-bit consumer path.

## Interface
- DEPTH, 8: FIFO depth in 64-bit entries; must be a power of two, ≥2.
- AW, $clog2(DEPTH): pointer address width; derived, not overridden.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data holds a word to write.
- in_data  in  64  input word.
- in_ready  out  1  FIFO not full; a write occurs when in_valid && in_ready.
- out_valid  out  1  out_data holds a valid beat.
- out_data  out  32  output beat.
- out_ready  in  1  consumer accepts the beat; a transfer occurs when out_valid && out_ready.
- level  out  AW+1  number of words held in the FIFO; excludes the word in the output holding register.
- ovf_cnt  out  16  count of dropped input words; active only with FIFO_DOWN_SPLIT_OVF_EN.

## Operation
- Storage: DEPTH×64 array; wr_ptr and rd_ptr are AW+1 bits wide, and the MSB distinguishes full from empty.
- empty = (wr_ptr == rd_ptr). full = (pointer LSBs equal and MSBs differ). in_ready = !full. level = wr_ptr − rd_ptr, taken modulo 2^(AW+1).
- Push: when in_valid && in_ready, mem[wr_ptr[AW-1:0]] ← in_data and wr_ptr increments. Pointers wrap naturally.
- Drop: in_valid && !in_ready discards the word. There is no backpressure beyond in_ready.
- Output stage has a 64-bit holding register `hold` and a three-state FSM:
  - IDLE: out_valid=0. If !empty, pop into hold (rd_ptr+1) and go to HI.
  - HI: out_valid=1, out_data=hold[63:32]. On out_ready, go to LO.
  - LO: out_valid=1, out_data=hold[31:0]. On out_ready: if !empty, pop into hold and go to HI with no bubble; otherwise go to IDLE.
- out_data is driven from registered hold and state, not directly from the array.
- A push and a pop in the same cycle are both performed, and level is unchanged.
- When full, in_ready=0 even if a pop occurs in that cycle, so a push is never accepted against a same-cycle pop.
- Reset: pointers, hold, FSM (IDLE), level and ovf_cnt clear immediately. All queued and in-flight data is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, level=0, ovf_cnt=0.
- Latency with the pipeline empty: push accepted at edge N → level=1 after N → pop at edge N+1 → out_valid=1 with the upper half after N+1. First beat is visible 2 cycles after in_valid.
- Sustained throughput with out_ready held high: one 32-bit beat per cycle, i.e. one input word per 2 cycles. in_valid every cycle therefore fills the FIFO.
- out_data and out_valid stay stable while out_valid && !out_ready.
- in_ready deasserts the cycle after the push that makes level=DEPTH.
- Asynchronous reset asserted mid-beat forces out_valid=0 without waiting for a clock edge. Release is synchronous to the next clk edge by the system.

## Configuration
- FIFO_DOWN_SPLIT_OVF_EN defined: ovf_cnt increments by 1 on each cycle with in_valid && !in_ready, saturates at 16'hFFFF, and clears only on rst.
- FIFO_DOWN_SPLIT_OVF_EN undefined: the counter logic is not built, and ovf_cnt is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Single word: push 64'h1122_3344_5566_7788 with out_ready=1 → out_valid rises 2 cycles later; beats 32'h11223344 then 32'h55667788; then out_valid=0 and level=0.
- Back-to-back: push 4 words (random, modulo 256 per half) with out_ready=1 → 8 consecutive beats with no gap in upper/lower order.
- Backpressure: push 1 word, hold out_ready=0 for 5 cycles → out_data stays 32'h11223344 with out_valid=1. Release → both halves delivered once each.
- Full and overflow, DEPTH=8, out_ready=0: push 10 words → one word moves to hold, the FIFO reaches level=8 and in_ready=0. With the macro, ovf_cnt=1; without it, ovf_cnt=0. Draining yields words 1–9 in order.
- Wrap-around: 40 words streamed with out_ready toggling 1/0 → output matches the input sequence exactly, and the pointer MSB toggles at least twice.
- Reset mid-operation: assert rst while state is LO with level=3 → out_valid=0, level=0 and in_ready=1 at once. After release, a new word is delivered correctly.
